// File: rtl/h264_bytestream_sink_if.sv
// Byte-stream bundle between the encoder's tobytes output, the sink and the
// downstream valid/ready consumer. The sink takes the slave view.
interface h264_bytestream_sink_if;
   logic [7:0] tobytes_BYTE;
   logic       tobytes_STROBE;
   logic       tobytes_DONE;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output tobytes_BYTE, tobytes_STROBE, tobytes_DONE, out_ready,
      input  out_byte, out_valid
   );

   modport slave (
      input  tobytes_BYTE, tobytes_STROBE, tobytes_DONE, out_ready,
      output out_byte, out_valid
   );
endinterface

// File: rtl/h264_bytestream_sink.sv
// Annex-B byte-stream sink: buffers the encoder's tobytes output in a FIFO,
// emits the fixed SPS/PPS header once after reset and a 00 00 00 01 start
// code after every DONE marker, on a registered valid/ready byte output.
module h264_bytestream_sink #(
   parameter int FIFO_DEPTH = 64,
   parameter int FIFO_AW    = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   h264_bytestream_sink_if.slave bs,
   output logic [15:0]          frame_count,
   output logic                 overflow,
   output logic [FIFO_AW:0]     fifo_level
);

   localparam logic [1:0] ST_HDR  = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_SC   = 2'd2;

   localparam logic [FIFO_AW:0] DEPTH_L = FIFO_DEPTH[FIFO_AW:0];
   localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

   // FIFO entry: {done, has_byte, byte}
   logic [9:0]         fifo_mem [FIFO_DEPTH];
   logic [FIFO_AW:0]   wr_ptr_reg, rd_ptr_reg;
   logic [FIFO_AW:0]   level;
   logic               fifo_empty, fifo_full;
   logic               push_req, push_ok, pop;
   logic [9:0]         head;

   logic [1:0]         state_reg;
   logic [4:0]         hdr_idx_reg;
   logic [1:0]         sc_idx_reg;
   logic [7:0]         out_byte_reg;
   logic               out_valid_reg;
   logic [15:0]        frame_count_reg;
   logic               overflow_reg;
   logic               load_en;

   // 24-byte SPS/PPS header with its start codes, trailing start code for slice 0.
   function automatic logic [7:0] hdr_byte(input logic [4:0] idx);
      case (idx)
         5'd3, 5'd15, 5'd23: hdr_byte = 8'h01;
         5'd4:  hdr_byte = 8'h67;
         5'd5:  hdr_byte = 8'h42;
         5'd7:  hdr_byte = 8'h28;
         5'd8:  hdr_byte = 8'hDA;
         5'd9:  hdr_byte = 8'h05;
         5'd10: hdr_byte = 8'h82;
         5'd11: hdr_byte = 8'h59;
         5'd16: hdr_byte = 8'h68;
         5'd17: hdr_byte = 8'hCE;
         5'd18: hdr_byte = 8'h38;
         5'd19: hdr_byte = 8'h80;
         default: hdr_byte = 8'h00;
      endcase
   endfunction

   assign level      = wr_ptr_reg - rd_ptr_reg;
   assign fifo_empty = (level == '0);
   assign fifo_full  = (level == DEPTH_L);
   assign head       = fifo_mem[rd_ptr_reg[FIFO_AW-1:0]];

   // The output register can take a new byte when idle or being accepted now.
   assign load_en  = !out_valid_reg || bs.out_ready;
   assign pop      = (state_reg == ST_DATA) && load_en && !fifo_empty;
   assign push_req = bs.tobytes_STROBE || bs.tobytes_DONE;
   // A same-cycle pop frees the head slot, so a full FIFO still accepts the push.
   assign push_ok  = push_req && (!fifo_full || pop);

   // FIFO storage write; no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr_reg[FIFO_AW-1:0]] <= {bs.tobytes_DONE, bs.tobytes_STROBE, bs.tobytes_BYTE};
   end

   // FIFO pointers and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         if (push_req && !push_ok)
            overflow_reg <= 1'b1;
      end
   end

   // Header / data / start-code sequencer driving the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_HDR;
         hdr_idx_reg     <= 5'd0;
         sc_idx_reg      <= 2'd0;
         out_byte_reg    <= 8'h00;
         out_valid_reg   <= 1'b0;
         frame_count_reg <= 16'd0;
      end else if (load_en) begin
         case (state_reg)
            ST_HDR: begin
               out_byte_reg  <= hdr_byte(hdr_idx_reg);
               out_valid_reg <= 1'b1;
               hdr_idx_reg   <= hdr_idx_reg + 5'd1;
               if (hdr_idx_reg == 5'd23)
                  state_reg <= ST_DATA;
            end
            ST_DATA: begin
               if (fifo_empty) begin
                  out_valid_reg <= 1'b0;
               end else if (head[8]) begin
                  out_byte_reg  <= head[7:0];
                  out_valid_reg <= 1'b1;
                  if (head[9]) begin
                     state_reg  <= ST_SC;
                     sc_idx_reg <= 2'd0;
                  end
               end else begin
                  // Marker without a byte: emit the first start-code byte right away.
                  out_byte_reg  <= 8'h00;
                  out_valid_reg <= 1'b1;
                  state_reg     <= ST_SC;
                  sc_idx_reg    <= 2'd1;
               end
            end
            ST_SC: begin
               out_byte_reg  <= (sc_idx_reg == 2'd3) ? 8'h01 : 8'h00;
               out_valid_reg <= 1'b1;
               sc_idx_reg    <= sc_idx_reg + 2'd1;
               if (sc_idx_reg == 2'd3) begin
                  frame_count_reg <= frame_count_reg + 16'd1;
                  state_reg       <= ST_DATA;
               end
            end
            default: state_reg <= ST_HDR;
         endcase
      end
   end

   assign bs.out_byte  = out_byte_reg;
   assign bs.out_valid = out_valid_reg;
   assign frame_count  = frame_count_reg;
   assign overflow     = overflow_reg;
   assign fifo_level   = level;

endmodule
